// File: rtl/hazard_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared definitions for the pipeline hazard sequencer:
//   - state_t    : sequencer FSM states (2-bit encodings)
//   - FWD_*      : EX operand-forwarding select codes
//   - sb_entry_t : one scoreboard slot describing an in-flight writer
//   - SB_*       : scoreboard slot indices (EX, MEM, WR)
//   - fwd_sel()  : priority encoder for the forwarding select
// ----------------------------------------------------------------------------
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    localparam logic [1:0] FWD_REG = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_MEM = 2'b01;  // operand from MEM-stage ALU result
    localparam logic [1:0] FWD_WR  = 2'b10;  // operand from WR-stage busW

    // Only the fields the hazard and branch checks consume are tracked.
    typedef struct packed {
        logic       valid;
        logic       regwr;
        logic [4:0] rw;
        logic       load;
        logic       branch;
    } sb_entry_t;

    localparam sb_entry_t SB_NOP = '{valid: 1'b0, regwr: 1'b0, rw: 5'd0,
                                     load: 1'b0, branch: 1'b0};

    localparam int SB_EX    = 0;
    localparam int SB_MEM   = 1;
    localparam int SB_WR    = 2;
    localparam int SB_DEPTH = 3;

    // The youngest producer wins: a hit on the instruction that will be in MEM
    // carries a newer value than one that will be in WR.
    function automatic logic [1:0] fwd_sel(input logic i_hit_mem, input logic i_hit_wr);
        if (i_hit_mem) begin
            return FWD_MEM;
        end
        if (i_hit_wr) begin
            return FWD_WR;
        end
        return FWD_REG;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundle between the CPU pipeline (master) and the hazard sequencer (slave).
//   id_*        : description of the instruction currently in ID
//   ex_taken    : branch condition of the instruction now in EX
//   pc_hold, ifid_hold, idex_bubble, ifid_flush : pipeline-register controls
//   fwd_a/fwd_b : EX operand selects (valid during EX)
//   stall_cnt/flush_cnt : saturating event counters
// ----------------------------------------------------------------------------
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_regwr;
    logic [4:0]       id_rw;
    logic             id_load;
    logic             id_branch;
    logic             ex_taken;
    logic             pc_hold;
    logic             ifid_hold;
    logic             idex_bubble;
    logic             ifid_flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_regwr, id_rw, id_load, id_branch, ex_taken,
        input  pc_hold, ifid_hold, idex_bubble, ifid_flush, fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_regwr, id_rw, id_load, id_branch, ex_taken,
        output pc_hold, ifid_hold, idex_bubble, ifid_flush, fwd_a, fwd_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl_match.sv
// ----------------------------------------------------------------------------
// hazard_match
// Compares one ID source register against one scoreboard writer.
//   i_valid, i_regwr, i_rw : scoreboard slot (occupied, writes a reg, dest)
//   i_r, i_use             : ID source register and whether ID reads it
//   o_match                : slot produces the register ID reads
// Register 0 is hard-wired to zero, so it never creates a dependency.
// ----------------------------------------------------------------------------
module hazard_match (
    input  logic       i_valid,
    input  logic       i_regwr,
    input  logic [4:0] i_rw,
    input  logic [4:0] i_r,
    input  logic       i_use,
    output logic       o_match
);
    assign o_match = i_valid & i_regwr & i_use & (i_rw == i_r) & (i_r != 5'd0);
endmodule

// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline sequencer for the 5-stage CPU. Tracks writers in EX/MEM/WR, stalls
// IF/ID on data hazards, registers EX forwarding selects and flushes the
// wrong path when a branch resolves taken in EX. Counts stall/flush cycles.
//   clk   : clock; state advances on the falling edge, like the pipeline regs
//   rst_n : synchronous active-low reset
//   bus   : hazard_ctrl_if slave (ID description in, controls/selects out)
// Parameters:
//   FWD_EN    : 1 forward from MEM/WR and stall only on load-use; 0 stall on
//               any EX/MEM producer
//   WB_BYPASS : 1 regfile writes before read; 0 also stall on a WR producer
//   CNT_W     : counter width
// ----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int FWD_EN    = 1,
    parameter int WB_BYPASS = 1,
    parameter int CNT_W     = 16
) (
    input logic          clk,
    input logic          rst_n,
    hazard_ctrl_if.slave bus
);
    localparam bit L_FWD   = (FWD_EN != 0);
    localparam bit L_WR_HZ = (WB_BYPASS == 0);

    state_t           r_state;
    sb_entry_t        r_sb [SB_DEPTH];
    logic [1:0]       r_fwd_a;
    logic [1:0]       r_fwd_b;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic [SB_DEPTH-1:0] w_hit_rs;
    logic [SB_DEPTH-1:0] w_hit_rt;
    logic [SB_DEPTH-1:0] w_hit;
    logic                w_id_nop;
    logic                w_taken;
    logic                w_hazard;
    logic                w_stall;
    logic                w_load_ex;
    logic [1:0]          w_fwd_a_next;
    logic [1:0]          w_fwd_b_next;
    sb_entry_t           w_ex_next;

    // One comparator per (stage, operand) pair.
    generate
        for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_match
            hazard_match u_rs (
                .i_valid (r_sb[gi].valid),
                .i_regwr (r_sb[gi].regwr),
                .i_rw    (r_sb[gi].rw),
                .i_r     (bus.id_rs),
                .i_use   (bus.id_use_rs),
                .o_match (w_hit_rs[gi])
            );
            hazard_match u_rt (
                .i_valid (r_sb[gi].valid),
                .i_regwr (r_sb[gi].regwr),
                .i_rw    (r_sb[gi].rw),
                .i_r     (bus.id_rt),
                .i_use   (bus.id_use_rt),
                .o_match (w_hit_rt[gi])
            );
            assign w_hit[gi] = w_hit_rs[gi] | w_hit_rt[gi];
        end
    endgenerate

    // After a flush (and after reset) ID holds a NOP whatever id_* says.
    assign w_id_nop = (r_state == ST_FLUSH);
    assign w_taken  = r_sb[SB_EX].valid & r_sb[SB_EX].branch & bus.ex_taken;

    assign w_hazard = ~w_id_nop &
                      ((L_FWD ? (w_hit[SB_EX] & r_sb[SB_EX].load)
                              : (w_hit[SB_EX] | w_hit[SB_MEM]))
                       | (L_WR_HZ & w_hit[SB_WR]));

    // A taken branch kills the ID instruction, so its stall is moot.
    assign w_stall   = ~w_taken & w_hazard;
    assign w_load_ex = ~w_id_nop & ~w_taken & ~w_stall;

    // Current EX/MEM become MEM/WR when the ID instruction reaches EX.
    assign w_fwd_a_next = (L_FWD && w_load_ex) ? fwd_sel(w_hit_rs[SB_EX], w_hit_rs[SB_MEM]) : FWD_REG;
    assign w_fwd_b_next = (L_FWD && w_load_ex) ? fwd_sel(w_hit_rt[SB_EX], w_hit_rt[SB_MEM]) : FWD_REG;

    always_comb begin
        w_ex_next = SB_NOP;
        if (w_load_ex) begin
            w_ex_next.valid  = 1'b1;
            w_ex_next.regwr  = bus.id_regwr;
            w_ex_next.rw     = bus.id_rw;
            w_ex_next.load   = bus.id_load;
            w_ex_next.branch = bus.id_branch;
        end
    end

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_FLUSH;
            r_fwd_a     <= FWD_REG;
            r_fwd_b     <= FWD_REG;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                r_sb[i] <= SB_NOP;
            end
        end else begin
            r_sb[SB_WR]  <= r_sb[SB_MEM];
            r_sb[SB_MEM] <= r_sb[SB_EX];
            r_sb[SB_EX]  <= w_ex_next;
            r_fwd_a      <= w_fwd_a_next;
            r_fwd_b      <= w_fwd_b_next;

            if (w_taken) begin
                r_state <= ST_FLUSH;
            end else if (w_stall) begin
                r_state <= ST_STALL;
            end else begin
                r_state <= ST_RUN;
            end

            if (w_taken && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    // Stall/flush controls act in the same cycle as their cause.
    assign bus.pc_hold     = w_stall;
    assign bus.ifid_hold   = w_stall;
    assign bus.idex_bubble = w_taken | w_stall;
    assign bus.ifid_flush  = w_taken;
    assign bus.fwd_a       = r_fwd_a;
    assign bus.fwd_b       = r_fwd_b;
    assign bus.stall_cnt   = r_stall_cnt;
    assign bus.flush_cnt   = r_flush_cnt;

endmodule
